// File: rtl/led_pattern_seq_if.sv
// ---------------------------------------------------------------------------
// led_pattern_seq_if
//   Bundles the control and LED signals of the LED pattern sequencer.
//
//   Signals
//     mode    2      pattern select: 0=walk, 1=count, 2=blink, 3=bounce
//     pause   1      1 = freeze the prescaler (no step, no LED change)
//     tick_o  1      one-cycle strobe while a freshly stepped LED value is shown
//     led     LED_W  registered LED pattern, bit 0 = rightmost LED
//     dbg_dir 1      bounce direction state (0=UP, 1=DOWN), observation only
//
//   Handshake: there is no valid/ready pair. mode/pause are level inputs
//   sampled on every clk edge; tick_o is a pure strobe with no backpressure,
//   and led is valid on every cycle (tick_o only flags that it just changed).
//
//   Modports
//     master : the controller side (drives mode/pause, observes outputs)
//     slave  : the sequencer side (led_pattern_seq)
// ---------------------------------------------------------------------------
interface led_pattern_seq_if #(
    parameter int LED_W = 5
);
    logic [1:0]       mode;
    logic             pause;
    logic             tick_o;
    logic [LED_W-1:0] led;
    logic             dbg_dir;

    modport master (
        output mode,
        output pause,
        input  tick_o,
        input  led,
        input  dbg_dir
    );

    modport slave (
        input  mode,
        input  pause,
        output tick_o,
        output led,
        output dbg_dir
    );
endinterface

// File: rtl/led_pattern_seq.sv
// ---------------------------------------------------------------------------
// led_pattern_seq
//   Timed LED pattern sequencer. A prescaler divides clk down to a step tick;
//   on each step the LED register advances one step of the selected pattern
//   (walking one, binary count, blink, bounce). A change of mode is applied
//   as a load of that pattern's initial value on the next step.
//
//   Parameters
//     DIV    clk cycles per pattern step (>= 1)
//     LED_W  LED bus width (>= 2)
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   led_pattern_seq_if.slave : mode, pause in; tick_o, led, dbg_dir out
// ---------------------------------------------------------------------------
module led_pattern_seq #(
    parameter int DIV   = 25_000_000,
    parameter int LED_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_seq_if.slave   bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    localparam logic [1:0] M_WALK   = 2'd0;
    localparam logic [1:0] M_COUNT  = 2'd1;
    localparam logic [1:0] M_BLINK  = 2'd2;
    localparam logic [1:0] M_BOUNCE = 2'd3;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    logic [CW-1:0]    cnt;
    logic [1:0]       mode_q;
    dir_t             dir;
    logic [LED_W-1:0] led_r;
    logic             tick_r;

    // Shifted versions of the current pattern, used by the bounce mode so
    // the direction flip can look at the value being loaded.
    logic [LED_W-1:0] led_up;
    logic [LED_W-1:0] led_dn;

    always_comb begin
        led_up = led_r << 1;
        led_dn = led_r >> 1;
    end

    // Initial value of each pattern, loaded on the first step after a mode change.
    function automatic logic [LED_W-1:0] init_of(input logic [1:0] m);
        logic [LED_W-1:0] v;
        v = '0;
        if (m == M_WALK || m == M_BOUNCE) begin
            v = LED_W'(1);
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mode_q <= M_WALK;
            dir    <= UP;
            led_r  <= LED_W'(1);
            tick_r <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (!bus.pause) begin
                if (cnt == CNT_LAST) begin
                    cnt    <= '0;
                    tick_r <= 1'b1;
                    if (bus.mode != mode_q) begin
                        // Mode change: load only, no advance on this step.
                        mode_q <= bus.mode;
                        dir    <= UP;
                        led_r  <= init_of(bus.mode);
                    end else begin
                        case (mode_q)
                            M_WALK:  led_r <= {led_r[LED_W-2:0], led_r[LED_W-1]};
                            M_COUNT: led_r <= led_r + LED_W'(1);
                            M_BLINK: led_r <= ~led_r;
                            default: begin
                                // Flip direction as soon as an end position is
                                // reached so that end is shown exactly once.
                                if (dir == UP) begin
                                    led_r <= led_up;
                                    if (led_up[LED_W-1]) dir <= DOWN;
                                end else begin
                                    led_r <= led_dn;
                                    if (led_dn[0]) dir <= UP;
                                end
                            end
                        endcase
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.led     = led_r;
    assign bus.tick_o  = tick_r;
    assign bus.dbg_dir = dir;
endmodule
